// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus pixel capture.
// Registers the camera bus once, assembles two-byte RGB565 pixels, tracks
// line/frame position, discards settling frames after enable, checks frame
// geometry and presents pixels on a single-entry valid/ready output register.
// Everything runs in the camera pixel-clock domain.
module ov7670_pixel_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        vsync_i,
  input  logic        href_i,
  input  logic [7:0]  data_i,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        pix_sof_o,
  output logic        pix_eol_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic        line_err_o,
  output logic        overflow_o,
  output logic        busy_o
);

  // The skip counter only needs to hold SKIP_FRAMES; keep at least one bit
  // so SKIP_FRAMES = 0 still elaborates.
  localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0]  H_COUNT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  V_COUNT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_FRAMES);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    SKIP,
    WAIT_FS,
    ACTIVE
  } state_t;

  state_t state;
  state_t state_next;

  // Input q-stage and its one-cycle history used for edge detection
  logic        vsync_q;
  logic        href_q;
  logic [7:0]  data_q;
  logic        vsync_qq;
  logic        href_qq;

  logic        vs_rise;
  logic        vs_fall;
  logic        href_fall;

  // Control strobes decoded by the FSM
  logic        load_skip;
  logic        dec_skip;
  logic        start_frame;
  logic        end_frame;

  // Datapath state
  logic [SKIP_W-1:0] skip_cnt;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  line_cnt;
  logic              phase;
  logic [7:0]        hi_byte;
  logic              frame_err;

  logic        line_end;
  logic        bad_line;
  logic        pix_fire;
  logic [15:0] pix_new;
  logic        sof_new;
  logic        eol_new;
  logic        pix_load;
  logic        pix_drop;

  // Single register stage on the camera pins; cleared by reset so no stale
  // edge survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      data_q   <= 8'h00;
      vsync_qq <= 1'b0;
      href_qq  <= 1'b0;
    end else begin
      vsync_q  <= vsync_i;
      href_q   <= href_i;
      data_q   <= data_i;
      vsync_qq <= vsync_q;
      href_qq  <= href_q;
    end
  end

  assign vs_rise   =  vsync_q & ~vsync_qq;
  assign vs_fall   = ~vsync_q &  vsync_qq;
  assign href_fall = ~href_q  &  href_qq;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and control strobes; enable is only looked at in IDLE
  // and at the end of a streamed frame.
  always_comb begin
    state_next  = state;
    load_skip   = 1'b0;
    dec_skip    = 1'b0;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          load_skip  = 1'b1;
          state_next = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (vs_rise) begin
          state_next = (skip_cnt != '0) ? SKIP : WAIT_FS;
        end
      end
      SKIP: begin
        if (vs_rise) begin
          dec_skip = 1'b1;
          if (skip_cnt <= SKIP_ONE) begin
            state_next = WAIT_FS;
          end
        end
      end
      WAIT_FS: begin
        if (vs_fall) begin
          start_frame = 1'b1;
          state_next  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          end_frame  = 1'b1;
          state_next = enable_i ? WAIT_FS : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy_o = (state != IDLE);

  // Settling-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= '0;
    end else if (load_skip) begin
      skip_cnt <= SKIP_LOAD;
    end else if (dec_skip && (skip_cnt != '0)) begin
      skip_cnt <= skip_cnt - SKIP_ONE;
    end
  end

  assign line_end = (state == ACTIVE) && href_fall;
  assign bad_line = line_end && (phase || (pix_cnt != H_COUNT));
  assign pix_fire = (state == ACTIVE) && href_q && phase;
  assign pix_new  = {hi_byte, data_q};
  assign sof_new  = (pix_cnt == '0) && (line_cnt == '0);
  assign eol_new  = (pix_cnt == H_LAST);
  assign pix_load = pix_fire && (!pix_valid_o || pix_ready_i);
  assign pix_drop = pix_fire && pix_valid_o && !pix_ready_i;

  // Byte phase, high-byte holding register and pixel/line position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 1'b0;
      hi_byte  <= 8'h00;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (start_frame) begin
      phase    <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (line_end) begin
      phase   <= 1'b0;
      pix_cnt <= '0;
      if (line_cnt != CNT_MAX) begin
        line_cnt <= line_cnt + CNT_ONE;
      end
    end else if ((state == ACTIVE) && href_q) begin
      if (!phase) begin
        hi_byte <= data_q;
        phase   <= 1'b1;
      end else begin
        phase <= 1'b0;
        if (pix_cnt != CNT_MAX) begin
          pix_cnt <= pix_cnt + CNT_ONE;
        end
      end
    end
  end

  // Single-entry output register; a held pixel is never overwritten, the
  // newcomer is dropped instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_o <= 1'b0;
      pix_data_o  <= 16'h0000;
      pix_sof_o   <= 1'b0;
      pix_eol_o   <= 1'b0;
    end else if (pix_load) begin
      pix_valid_o <= 1'b1;
      pix_data_o  <= pix_new;
      pix_sof_o   <= sof_new;
      pix_eol_o   <= eol_new;
    end else if (pix_valid_o && pix_ready_i) begin
      pix_valid_o <= 1'b0;
      pix_data_o  <= 16'h0000;
      pix_sof_o   <= 1'b0;
      pix_eol_o   <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_err_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (bad_line) begin
        line_err_o <= 1'b1;
      end
      if (pix_drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Per-frame error accumulator, restarted when a streamed frame begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (start_frame) begin
      frame_err <= 1'b0;
    end else if (bad_line || pix_drop) begin
      frame_err <= 1'b1;
    end
  end

  // End-of-frame pulse with its geometry/health verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_o <= 1'b0;
      frame_ok_o   <= 1'b0;
    end else begin
      frame_done_o <= end_frame;
      frame_ok_o   <= end_frame && (line_cnt == V_COUNT) && !frame_err;
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Self-checking bench for ov7670_pixel_capture (H_ACTIVE=4, V_ACTIVE=2,
// SKIP_FRAMES=1). Stimulus pushes expected pixels and frame verdicts into
// queues; an independent monitor pops them on each handshake / frame_done.
module tb_ov7670_pixel_capture;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int SKIP = 1;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        frame_done;
  logic        frame_ok;
  logic        line_err;
  logic        overflow;
  logic        busy;

  pix_t exp_pix[$];
  bit   exp_ok[$];
  int   tests = 0;
  int   fails = 0;
  bit   hold_ready = 1'b0;
  int   line_len[4];
  logic [7:0] frame_bytes[4][32];

  ov7670_pixel_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .SKIP_FRAMES(SKIP),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(enable),
    .vsync_i(vsync),
    .href_i(href),
    .data_i(data),
    .pix_data_o(pix_data),
    .pix_valid_o(pix_valid),
    .pix_ready_i(pix_ready),
    .pix_sof_o(pix_sof),
    .pix_eol_o(pix_eol),
    .frame_done_o(frame_done),
    .frame_ok_o(frame_ok),
    .line_err_o(line_err),
    .overflow_o(overflow),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic vsyncPulse();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  // Drives one frame (leading VSYNC pulse then the lines in line_len).
  // When streamed, the expected pixels and verdict come from the rules:
  // byte pairs form pixels, SOF on pixel 0 of line 0, EOL on pixel H-1,
  // a frame is good only with V lines of exactly 2*H bytes and no drops.
  // With hold set the consumer stalls all frame: only the first pixel survives.
  task automatic applyStimulus(input int nlines, input bit streamed,
                               input bit counting, input bit hold);
    int   cnt = 1;
    int   total = 0;
    bit   ok;
    pix_t p;
    for (int l = 0; l < nlines; l++) begin
      for (int i = 0; i < line_len[l]; i++) begin
        frame_bytes[l][i] = counting ? 8'(cnt) : 8'($urandom_range(0, 255));
        cnt++;
      end
    end
    if (streamed) begin
      ok = (nlines == V);
      for (int l = 0; l < nlines; l++) begin
        if (line_len[l] != 2 * H) ok = 1'b0;
        for (int k = 0; k < line_len[l] / 2; k++) begin
          if (!hold || total == 0) begin
            p.data = {frame_bytes[l][2*k], frame_bytes[l][2*k+1]};
            p.sof  = (l == 0) && (k == 0);
            p.eol  = (k == H - 1);
            exp_pix.push_back(p);
          end
          total++;
        end
      end
      if (hold && total > 1) ok = 1'b0;
      exp_ok.push_back(ok);
    end
    vsyncPulse();
    hold_ready = hold;
    for (int l = 0; l < nlines; l++) begin
      for (int i = 0; i < line_len[l]; i++) begin
        href = 1'b1;
        data = frame_bytes[l][i];
        tick();
      end
      href = 1'b0;
      data = 8'h00;
      repeat (4) tick();
    end
    hold_ready = 1'b0;
  endtask

  // Consumer: random ready, never low twice in a row so a continuous line
  // cannot overflow unless the bench deliberately holds it low.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (hold_ready) pix_ready = 1'b0;
      else if (!pix_ready) pix_ready = 1'b1;
      else pix_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: sampled mid-cycle, the handshake/pulse takes effect next edge
  always @(negedge clk) begin
    pix_t p;
    bit   ok;
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        if (exp_pix.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pixel: got %0h expected none", pix_data);
        end else begin
          p = exp_pix.pop_front();
          checkOutput("pix_data", {16'h0, pix_data}, {16'h0, p.data});
          checkOutput("pix_sof", {31'h0, pix_sof}, {31'h0, p.sof});
          checkOutput("pix_eol", {31'h0, pix_eol}, {31'h0, p.eol});
        end
      end
      if (frame_done) begin
        if (exp_ok.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_frame_done: got 1 expected 0");
        end else begin
          ok = exp_ok.pop_front();
          checkOutput("frame_ok", {31'h0, frame_ok}, {31'h0, ok});
        end
      end
    end
  end

  // Global bound so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wait_cycles;
    rst_n  = 1'b0;
    enable = 1'b0;
    vsync  = 1'b0;
    href   = 1'b0;
    data   = 8'h00;
    repeat (3) tick();
    checkOutput("rst_valid", {31'h0, pix_valid}, 32'h0);
    checkOutput("rst_data", {16'h0, pix_data}, 32'h0);
    checkOutput("rst_flags", {26'h0, pix_sof, pix_eol, frame_done, frame_ok,
                line_err, overflow}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("idle_busy", {31'h0, busy}, 32'h0);

    // Enable in blanking: first frame skipped, second (counting bytes) streams
    enable = 1'b1;
    repeat (2) tick();
    checkOutput("enabled_busy", {31'h0, busy}, 32'h1);
    line_len = '{8, 8, 0, 0};
    applyStimulus(2, 1'b0, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) applyStimulus(2, 1'b1, 1'b0, 1'b0);
    checkOutput("line_err_clean", {31'h0, line_err}, 32'h0);

    // Odd line then over-long line
    line_len = '{7, 10, 0, 0};
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    checkOutput("line_err_set", {31'h0, line_err}, 32'h1);

    // Too many lines
    line_len = '{8, 8, 8, 0};
    applyStimulus(3, 1'b1, 1'b0, 1'b0);
    checkOutput("overflow_clean", {31'h0, overflow}, 32'h0);

    // Consumer stalled for a whole frame
    line_len = '{8, 8, 0, 0};
    applyStimulus(2, 1'b1, 1'b0, 1'b1);
    checkOutput("overflow_set", {31'h0, overflow}, 32'h1);

    // Enable dropped mid-frame only takes effect at frame end
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    vsyncPulse();
    checkOutput("disabled_busy", {31'h0, busy}, 32'h0);

    // Enable raised mid-frame: this partial frame and one settling frame vanish
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      data = 8'($urandom_range(0, 255));
      tick();
    end
    href = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      data = 8'($urandom_range(0, 255));
      tick();
    end
    href = 1'b0;
    repeat (4) tick();
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0);

    // Reset mid-line while a pixel is held
    hold_ready = 1'b1;
    vsyncPulse();
    for (int i = 0; i < 6; i++) begin
      href = 1'b1;
      data = 8'($urandom_range(0, 255));
      tick();
    end
    tick();
    checkOutput("held_valid", {31'h0, pix_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", {31'h0, pix_valid}, 32'h0);
    checkOutput("abort_data", {16'h0, pix_data}, 32'h0);
    checkOutput("abort_flags", {26'h0, pix_sof, pix_eol, frame_done, frame_ok,
                line_err, overflow}, 32'h0);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    exp_pix.delete();
    exp_ok.delete();
    href = 1'b0;
    data = 8'h00;
    hold_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    vsyncPulse();

    wait_cycles = 0;
    while ((exp_pix.size() != 0 || exp_ok.size() != 0) && wait_cycles < 200) begin
      tick();
      wait_cycles++;
    end
    checkOutput("pixels_drained", exp_pix.size(), 32'h0);
    checkOutput("frames_drained", exp_ok.size(), 32'h0);
    checkOutput("final_line_err", {31'h0, line_err}, 32'h0);
    checkOutput("final_overflow", {31'h0, overflow}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
